// File: rtl/lsu_rmw_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_rmw_ctrl_if
// Bundle of the request/response handshake and the data-memory port used by
// lsu_rmw_ctrl.
//   req_*  : load/store request from the pipeline (valid/ready handshake)
//   resp_* : one-cycle registered response pulse back to the pipeline
//   mem_*  : word-wide DMEM port (combinational read on mem_addr, write on clk)
// Modports:
//   slave  : the load/store controller itself
//   master : the environment (pipeline + DMEM) around the controller
// -----------------------------------------------------------------------------
interface lsu_rmw_ctrl_if #(
  parameter int MEM_ADDR_W = 10
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;

  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_rmw_ctrl
// RV32I load/store controller in front of a word-only DMEM. Loads and SW take
// one cycle; SB/SH are done as read (acceptance cycle) then full-word write of
// the merged word (MERGE cycle). Responses are registered one cycle after the
// last memory cycle of the request.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : lsu_rmw_ctrl_if.slave (request, response and DMEM port)
// Build option:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned LH/LHU/SH/LW/SW are
//   rejected with resp_err; when undefined the low address bits are forced to
//   natural alignment and the access proceeds.
// -----------------------------------------------------------------------------
module lsu_rmw_ctrl #(
  parameter int MEM_ADDR_W = 10,
  parameter int DATA_W     = 32
) (
  input  logic           clk,
  input  logic           rst,
  lsu_rmw_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_e;

  // Pick the addressed byte/half out of a word and extend it per funct3.
  function automatic logic [DATA_W-1:0] load_extend(
    input logic [DATA_W-1:0] word,
    input logic [2:0]        f3,
    input logic [1:0]        off
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    load_extend = {{24{b[7]}}, b};
      3'd1:    load_extend = {{16{h[15]}}, h};
      3'd2:    load_extend = word;
      3'd4:    load_extend = {24'd0, b};
      3'd5:    load_extend = {16'd0, h};
      default: load_extend = 32'd0;
    endcase
  endfunction

  // Replace the target byte/half lane of the old word with store data.
  function automatic logic [DATA_W-1:0] merge_store(
    input logic [DATA_W-1:0] word,
    input logic [DATA_W-1:0] wdata,
    input logic [2:0]        f3,
    input logic [1:0]        off
  );
    logic [DATA_W-1:0] r;
    r = word;
    case (f3)
      3'd0: r[{off, 3'b000} +: 8] = wdata[7:0];
      3'd1: begin
        if (off[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      default: r = word;
    endcase
    merge_store = r;
  endfunction

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     merge_word_q, merge_word_d;
  logic [MEM_ADDR_W-1:0] merge_addr_q, merge_addr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic                  accept_s;
  logic                  f3_legal_s;
  logic                  misalign_s;
  logic                  err_s;
  logic                  sub_store_s;
  logic [1:0]            size_s;
  logic [1:0]            off_s;
  logic [MEM_ADDR_W-1:0] word_addr_s;

  assign word_addr_s = bus.req_addr[MEM_ADDR_W+1:2];
  assign size_s      = bus.req_funct3[1:0];

  // Request decode: legality, alignment and the effective lane offset.
  always_comb begin
    accept_s   = bus.req_valid && (state_q == ST_IDLE);
    if (bus.req_we) begin
      f3_legal_s = (bus.req_funct3 <= 3'd2);
    end else begin
      f3_legal_s = (bus.req_funct3 == 3'd0) || (bus.req_funct3 == 3'd1) ||
                   (bus.req_funct3 == 3'd2) || (bus.req_funct3 == 3'd4) ||
                   (bus.req_funct3 == 3'd5);
    end
    misalign_s = ((size_s == 2'd1) && bus.req_addr[0]) ||
                 ((size_s == 2'd2) && (bus.req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    err_s = !f3_legal_s || misalign_s;
`else
    err_s = !f3_legal_s;
`endif
    // Halves and words ignore the address bits below their natural alignment.
    case (size_s)
      2'd0:    off_s = bus.req_addr[1:0];
      2'd1:    off_s = {bus.req_addr[1], 1'b0};
      default: off_s = 2'b00;
    endcase
    sub_store_s = bus.req_we && !err_s && (size_s != 2'd2);
  end

  // Next-state, DMEM port and response computation.
  always_comb begin
    state_d       = state_q;
    merge_word_d  = merge_word_q;
    merge_addr_d  = merge_addr_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = {DATA_W{1'b0}};
    resp_err_d    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {MEM_ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.req_ready = (state_q == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          bus.mem_addr = word_addr_s;
          resp_err_d   = err_s;
          if (err_s) begin
            resp_valid_d = 1'b1;
          end else if (!bus.req_we) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_extend(bus.mem_rdata, bus.req_funct3, off_s);
          end else if (sub_store_s) begin
            // Read cycle: the merged word is captured, the write follows.
            merge_word_d = merge_store(bus.mem_rdata, bus.req_wdata,
                                       bus.req_funct3, off_s);
            merge_addr_d = word_addr_s;
            state_d      = ST_MERGE;
          end else begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = bus.req_wdata;
            resp_valid_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MERGE: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = merge_addr_q;
        bus.mem_wdata = merge_word_q;
        resp_valid_d  = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      merge_word_q <= {DATA_W{1'b0}};
      merge_addr_q <= {MEM_ADDR_W{1'b0}};
      resp_valid_q <= 1'b0;
      resp_rdata_q <= {DATA_W{1'b0}};
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      merge_word_q <= merge_word_d;
      merge_addr_q <= merge_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_rmw_ctrl
// Table-driven directed test of lsu_rmw_ctrl against a behavioural word DMEM,
// plus hand-written back-to-back and reset-during-MERGE sequences.
// -----------------------------------------------------------------------------
module tb_lsu_rmw_ctrl;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_rmw_ctrl_if #(.MEM_ADDR_W(AW)) bus ();

  lsu_rmw_ctrl #(.MEM_ADDR_W(AW), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural DMEM with a bench-side preload port.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;     // word preloaded at the target address
    logic        e_wr;    // a memory write is expected
    logic        e_sub;   // write happens in a MERGE cycle
    logic [31:0] e_word;  // memory word after the request
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] pre, input logic e_wr,
                              input logic e_sub, input logic [31:0] e_word,
                              input logic [31:0] e_rdata, input logic e_err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.pre = pre;
    v.e_wr = e_wr; v.e_sub = e_sub; v.e_word = e_word; v.e_rdata = e_rdata; v.e_err = e_err;
    return v;
  endfunction

  vec_t vq[$];

  initial begin
    logic [AW-1:0] wa;
    // we f3 addr wdata pre | wr sub word rdata err
    vq.push_back(mk(1'b1, 3'd2, 32'h8,  32'h11223344, 32'h00000000, 1'b1, 1'b0, 32'h11223344, 32'h0, 1'b0));
    vq.push_back(mk(1'b0, 3'd0, 32'hB,  32'h0, 32'h11223344, 1'b0, 1'b0, 32'h11223344, 32'h00000011, 1'b0));
    vq.push_back(mk(1'b0, 3'd1, 32'h8,  32'h0, 32'h11223344, 1'b0, 1'b0, 32'h11223344, 32'h00003344, 1'b0));
    vq.push_back(mk(1'b0, 3'd4, 32'h9,  32'h0, 32'h000080FF, 1'b0, 1'b0, 32'h000080FF, 32'h00000080, 1'b0));
    vq.push_back(mk(1'b0, 3'd0, 32'h9,  32'h0, 32'h000080FF, 1'b0, 1'b0, 32'h000080FF, 32'hFFFFFF80, 1'b0));
    vq.push_back(mk(1'b0, 3'd5, 32'hA,  32'h0, 32'hF00D1234, 1'b0, 1'b0, 32'hF00D1234, 32'h0000F00D, 1'b0));
    vq.push_back(mk(1'b0, 3'd1, 32'hA,  32'h0, 32'hF00D1234, 1'b0, 1'b0, 32'hF00D1234, 32'hFFFFF00D, 1'b0));
    vq.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0));
    vq.push_back(mk(1'b0, 3'd3, 32'h8,  32'h0, 32'h11223344, 1'b0, 1'b0, 32'h11223344, 32'h0, 1'b1));
    vq.push_back(mk(1'b0, 3'd7, 32'h8,  32'h0, 32'h11223344, 1'b0, 1'b0, 32'h11223344, 32'h0, 1'b1));
    vq.push_back(mk(1'b1, 3'd3, 32'h8,  32'hFFFFFFFF, 32'h11223344, 1'b0, 1'b0, 32'h11223344, 32'h0, 1'b1));
    vq.push_back(mk(1'b1, 3'd0, 32'h9,  32'h00000055, 32'hAABBCCDD, 1'b1, 1'b1, 32'hAABB55DD, 32'h0, 1'b0));
    vq.push_back(mk(1'b1, 3'd1, 32'hE,  32'h00001234, 32'h89ABCDEF, 1'b1, 1'b1, 32'h1234CDEF, 32'h0, 1'b0));
    vq.push_back(mk(1'b1, 3'd0, 32'h0,  32'hFFFFFFA5, 32'h00000000, 1'b1, 1'b1, 32'h000000A5, 32'h0, 1'b0));
`ifdef LSU_MISALIGN_TRAP_EN
    vq.push_back(mk(1'b1, 3'd2, 32'h6,  32'h5A5A5A5A, 32'h01010101, 1'b0, 1'b0, 32'h01010101, 32'h0, 1'b1));
    vq.push_back(mk(1'b0, 3'd1, 32'h9,  32'h0, 32'h11223344, 1'b0, 1'b0, 32'h11223344, 32'h0, 1'b1));
    vq.push_back(mk(1'b1, 3'd1, 32'hB,  32'h0000BEEF, 32'h11223344, 1'b0, 1'b0, 32'h11223344, 32'h0, 1'b1));
`else
    vq.push_back(mk(1'b1, 3'd2, 32'h6,  32'h5A5A5A5A, 32'h01010101, 1'b1, 1'b0, 32'h5A5A5A5A, 32'h0, 1'b0));
    vq.push_back(mk(1'b0, 3'd1, 32'h9,  32'h0, 32'h11223344, 1'b0, 1'b0, 32'h11223344, 32'h00003344, 1'b0));
    vq.push_back(mk(1'b1, 3'd1, 32'hB,  32'h0000BEEF, 32'h11223344, 1'b1, 1'b1, 32'hBEEF3344, 32'h0, 1'b0));
`endif

    // Reset state.
    rst = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = 32'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    #3;
    chk("rst resp_valid", bus.resp_valid, 32'h0);
    chk("rst resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst resp_err",   bus.resp_err,   32'h0);
    chk("rst mem_we",     bus.mem_we,     32'h0);
    chk("rst req_ready",  bus.req_ready,  32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven single requests.
    for (int i = 0; i < vq.size(); i++) begin
      wa = vq[i].addr[AW+1:2];
      preload(wa, vq[i].pre);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = vq[i].we; bus.req_funct3 = vq[i].f3;
      bus.req_addr = vq[i].addr; bus.req_wdata = vq[i].wdata;
      #2;
      chk($sformatf("v%0d req_ready", i), bus.req_ready, 32'h1);
      chk($sformatf("v%0d mem_we", i), bus.mem_we, {31'd0, vq[i].e_wr && !vq[i].e_sub});
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, {22'd0, wa});
      if (vq[i].e_wr && !vq[i].e_sub)
        chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vq[i].e_word);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      if (vq[i].e_sub) begin
        chk($sformatf("v%0d merge resp_valid", i), bus.resp_valid, 32'h0);
        chk($sformatf("v%0d merge req_ready", i), bus.req_ready, 32'h0);
        chk($sformatf("v%0d merge mem_we", i), bus.mem_we, 32'h1);
        chk($sformatf("v%0d merge mem_addr", i), bus.mem_addr, {22'd0, wa});
        chk($sformatf("v%0d merge mem_wdata", i), bus.mem_wdata, vq[i].e_word);
        @(posedge clk); #1;
      end
      chk($sformatf("v%0d resp_valid", i), bus.resp_valid, 32'h1);
      chk($sformatf("v%0d resp_rdata", i), bus.resp_rdata, vq[i].e_rdata);
      chk($sformatf("v%0d resp_err", i), bus.resp_err, {31'd0, vq[i].e_err});
      chk($sformatf("v%0d mem word", i), mem[wa], vq[i].e_word);
      @(posedge clk); #1;
      chk($sformatf("v%0d resp_valid drop", i), bus.resp_valid, 32'h0);
    end

    // Back-to-back LW, LW, SH, LW: responses at cycles 1, 2, 4, 5.
    preload(10'd4, 32'hA0A0A0A0);
    preload(10'd5, 32'hB1B1B1B1);
    preload(10'd6, 32'h01234567);
    for (int c = 0; c < 7; c++) begin
      logic        exp_rv;
      logic [31:0] exp_rd;
      @(negedge clk);
      bus.req_valid = (c < 5); bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_wdata = 32'h0;
      case (c)
        0:       bus.req_addr = 32'h10;
        1:       bus.req_addr = 32'h14;
        2:       begin bus.req_addr = 32'h1A; bus.req_we = 1'b1; bus.req_funct3 = 3'd1; bus.req_wdata = 32'h0000BEEF; end
        default: bus.req_addr = 32'h18;
      endcase
      #2;
      if (c < 5) chk($sformatf("b2b c%0d req_ready", c), bus.req_ready, {31'd0, c != 3});
      @(posedge clk); #1;
      case (c + 1)
        1:       begin exp_rv = 1'b1; exp_rd = 32'hA0A0A0A0; end
        2:       begin exp_rv = 1'b1; exp_rd = 32'hB1B1B1B1; end
        4:       begin exp_rv = 1'b1; exp_rd = 32'h00000000; end
        5:       begin exp_rv = 1'b1; exp_rd = 32'hBEEF4567; end
        default: begin exp_rv = 1'b0; exp_rd = 32'h0; end
      endcase
      chk($sformatf("b2b c%0d resp_valid", c + 1), bus.resp_valid, {31'd0, exp_rv});
      if (exp_rv) chk($sformatf("b2b c%0d resp_rdata", c + 1), bus.resp_rdata, exp_rd);
    end
    bus.req_valid = 1'b0;

    // Reset during the MERGE cycle of an SB aborts the write.
    preload(10'd7, 32'hCAFEF00D);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h1C; bus.req_wdata = 32'h00000077;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstm merge mem_we", bus.mem_we, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstm mem_we",     bus.mem_we,     32'h0);
    chk("rstm mem_addr",   bus.mem_addr,   32'h0);
    chk("rstm mem_wdata",  bus.mem_wdata,  32'h0);
    chk("rstm req_ready",  bus.req_ready,  32'h1);
    chk("rstm resp_valid", bus.resp_valid, 32'h0);
    chk("rstm resp_rdata", bus.resp_rdata, 32'h0);
    chk("rstm resp_err",   bus.resp_err,   32'h0);
    @(posedge clk); #1;
    chk("rstm resp_valid held", bus.resp_valid, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rstm after%0d resp_valid", k), bus.resp_valid, 32'h0);
    end
    chk("rstm word unchanged", mem[7], 32'hCAFEF00D);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h1C;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstm LW resp_valid", bus.resp_valid, 32'h1);
    chk("rstm LW resp_rdata", bus.resp_rdata, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
